// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: on start, emits a sync pattern followed by a
// parallel data word (MSB first) on dout, one bit per clock. All outputs are
// registered; a start in the done cycle chains frames with no idle gap.
module serial_frame_tx #(
  parameter int unsigned        WIDTH      = 8,
  parameter int unsigned        PAT_LEN    = 4,
  parameter logic [PAT_LEN-1:0] PATTERN    = 4'b0110,
  parameter logic               IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FrameW = PAT_LEN + WIDTH;
  localparam int unsigned MaxLen = (PAT_LEN > WIDTH) ? PAT_LEN : WIDTH;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StData
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FrameW-1:0]   shift_q, shift_d;
  logic                dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic [FrameW-1:0]   load_frame;

  // Whole frame is loaded at once; the first bit goes straight to dout, so
  // the register keeps the remaining bits left-aligned.
  assign load_frame = {PATTERN, data};

  // Next-state logic: cnt_q holds the index of the bit currently on dout
  // within its phase, counting down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = IDLE_LEVEL;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start;
      end
      StSync: begin
        dout_d  = shift_q[FrameW-1];
        shift_d = shift_q << 1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == '0) begin
          state_d = StData;
          cnt_d   = CntW'(WIDTH - 1);
          done_d  = (WIDTH == 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          // Done cycle: either chain a new frame or fall back to idle.
          state_d = StIdle;
          cnt_d   = '0;
          accept  = start;
        end else begin
          dout_d  = shift_q[FrameW-1];
          shift_d = shift_q << 1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          done_d  = (cnt_q == CntW'(1));
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d = StSync;
      cnt_d   = CntW'(PAT_LEN - 1);
      shift_d = load_frame << 1;
      dout_d  = PATTERN[PAT_LEN-1];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a hand-written vector table for one frame,
// directed multi-cycle sequences, and random stimulus against a queue model
// of the outgoing bit stream.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dout, dout_valid, busy, done;

  int errors = 0;
  int checks = 0;

  // Model: the bits still to appear on dout; element 0 is the bit on dout now.
  logic       q[$];
  logic [3:0] pat = 4'b0110;

  serial_frame_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic [3:0] exp;  // {dout, dout_valid, busy, done}
  } vec_t;

  vec_t vecs[13];

  // Advance the model across one rising edge with the sampled inputs.
  task automatic model_edge(input logic s, input logic [7:0] d);
    logic accept;
    if (!reset) begin
      q.delete();
    end else begin
      // A new frame is taken only when idle or on the frame's last bit.
      accept = s && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (accept) begin
        for (int i = 3; i >= 0; i--) q.push_back(pat[i]);
        for (int i = 7; i >= 0; i--) q.push_back(d[i]);
      end
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {dout, dout_valid, busy, done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {dout,valid,busy,done}=%b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] model_exp();
    if (q.size() == 0) return 4'b0000;
    return {q[0], 1'b1, 1'b1, q.size() == 1};
  endfunction

  // Drive inputs, take one edge, then compare against the model.
  task automatic step(input string name, input logic s, input logic [7:0] d);
    start = s;
    data  = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
    check_out(name, model_exp());
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 4'b0110};
    vecs[1]  = '{1'b0, 8'hFF, 4'b1110};
    vecs[2]  = '{1'b0, 8'h00, 4'b1110};
    vecs[3]  = '{1'b0, 8'hFF, 4'b0110};
    vecs[4]  = '{1'b0, 8'h00, 4'b1110};
    vecs[5]  = '{1'b0, 8'hFF, 4'b0110};
    vecs[6]  = '{1'b0, 8'h00, 4'b1110};
    vecs[7]  = '{1'b0, 8'hFF, 4'b0110};
    vecs[8]  = '{1'b0, 8'h00, 4'b0110};
    vecs[9]  = '{1'b0, 8'hFF, 4'b1110};
    vecs[10] = '{1'b0, 8'h00, 4'b0110};
    vecs[11] = '{1'b0, 8'hFF, 4'b1111};
    vecs[12] = '{1'b0, 8'h00, 4'b0000};

    // Reset held with start asserted: outputs stay cleared.
    #1;
    check_out("reset_t0", 4'b0000);
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 8'hA5);
    reset = 1'b1;
    step("idle", 1'b0, 8'h00);
    step("idle", 1'b0, 8'h00);

    // Single A5 frame from the literal table.
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start;
      data  = vecs[i].data;
      @(posedge clk);
      model_edge(vecs[i].start, vecs[i].data);
      #1;
      check_out($sformatf("table_%0d", i), vecs[i].exp);
    end

    // Start while busy is ignored; data changes do not leak into the frame.
    step("busy_start", 1'b1, 8'h3C);
    for (int i = 2; i <= 15; i++) step("busy_start", (i == 6), 8'hFF);

    // Back-to-back frames: start in the done cycle.
    step("b2b", 1'b1, 8'h0F);
    for (int i = 2; i <= 12; i++) step("b2b", 1'b0, 8'h00);
    step("b2b", 1'b1, 8'hF0);
    for (int i = 2; i <= 14; i++) step("b2b", 1'b0, 8'h00);

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    step("mid_reset", 1'b1, 8'hA5);
    for (int i = 2; i <= 7; i++) step("mid_reset", 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    #1;
    check_out("async_clear", 4'b0000);
    step("mid_reset_hold", 1'b0, 8'h00);
    step("mid_reset_hold", 1'b0, 8'h00);
    reset = 1'b1;
    step("post_reset", 1'b0, 8'h00);
    step("post_reset", 1'b1, 8'hC3);
    for (int i = 2; i <= 14; i++) step("post_reset", 1'b0, 8'h00);

    // Payload that aliases the sync pattern.
    step("alias", 1'b1, 8'h66);
    for (int i = 2; i <= 14; i++) step("alias", 1'b0, 8'h00);

    // Random traffic, biased toward chaining in the done cycle.
    for (int i = 0; i < 600; i++) begin
      logic s;
      if (q.size() == 1) s = 1'($urandom_range(0, 1));
      else               s = ($urandom_range(0, 3) == 0);
      step("random", s, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
